// File: rtl/cnn_layer_accel_trans_eg_arb_pkg.sv
// Shared types and widths for the transfer egress packet arbiter.
package cnn_layer_accel_trans_eg_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Per-packet beat counter width (saturating)
  localparam int unsigned BEAT_CNT_WTH = 16;

  // Per-requester completed-packet statistic width (wrapping)
  localparam int unsigned STAT_CNT_WTH = 32;

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// Combinational round-robin pick: the search starts just after the last grant and wraps.
module cnn_layer_accel_rr_arb #(
  parameter int unsigned C_NUM_REQ = 4,
  parameter int unsigned C_ID_WTH  = $clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [C_ID_WTH-1:0]  last_gnt,
  output logic [C_NUM_REQ-1:0] gnt_onehot,
  output logic [C_ID_WTH-1:0]  gnt_idx,
  output logic                 any
);

  // First requester found scanning last_gnt+1, last_gnt+2, ... modulo C_NUM_REQ
  always_comb begin
    int unsigned idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int unsigned off = 1; off <= C_NUM_REQ; off++) begin
      idx = (32'(last_gnt) + off) % C_NUM_REQ;
      if (!any && req[C_ID_WTH'(idx)]) begin
        any                            = 1'b1;
        gnt_idx                        = C_ID_WTH'(idx);
        gnt_onehot[C_ID_WTH'(idx)]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_trans_eg_arb.sv
// Round-robin packet arbiter for the transfer egress FIFO write port.
// Grants whole packets and never interleaves beats of different requesters.
// Optional build macro TRANS_EG_ARB_STATS_EN adds per-requester packet counters.
module cnn_layer_accel_trans_eg_arb
  import cnn_layer_accel_trans_eg_arb_pkg::*;
#(
  parameter int unsigned C_NUM_REQ   = 4,
  parameter int unsigned C_META_WTH  = 64,
  parameter int unsigned C_PYLD_WTH  = 1024,
  parameter int unsigned C_MAX_BEATS = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [C_NUM_REQ-1:0]                  req_vld,
  input  logic [C_NUM_REQ-1:0]                  req_last,
  input  logic [C_NUM_REQ*C_META_WTH-1:0]       req_meta,
  input  logic [C_NUM_REQ*C_PYLD_WTH-1:0]       req_pyld,
  output logic [C_NUM_REQ-1:0]                  req_rdy,
  output logic [C_META_WTH+C_PYLD_WTH-1:0]      fifo_din,
  output logic                                  fifo_wr_en,
  input  logic                                  fifo_full,
  input  logic                                  fifo_wr_rst_busy,
  output logic [$clog2(C_NUM_REQ)-1:0]          gnt_id,
  output logic                                  busy,
  output logic                                  pkt_err,
  output logic [C_NUM_REQ*STAT_CNT_WTH-1:0]     stat_pkt_cnt
);

  localparam int unsigned C_ID_WTH = $clog2(C_NUM_REQ);
  localparam int unsigned C_DIN_WTH = C_META_WTH + C_PYLD_WTH;

  arb_state_e                state;
  logic [C_NUM_REQ-1:0]      gnt_oh;
  logic [BEAT_CNT_WTH-1:0]   beat_cnt;
  logic [C_NUM_REQ-1:0]      arb_onehot;
  logic [C_ID_WTH-1:0]       arb_idx;
  logic                      arb_any;
  logic [C_NUM_REQ-1:0]      beat_acc;
  logic                      acc_any;
  logic                      acc_last;

  cnn_layer_accel_rr_arb #(
    .C_NUM_REQ (C_NUM_REQ),
    .C_ID_WTH  (C_ID_WTH)
  ) u_rr_arb (
    .req        (req_vld),
    .last_gnt   (gnt_id),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // Handshake decode for the granted requester
  always_comb begin
    beat_acc = req_vld & req_rdy;
    acc_any  = |beat_acc;
    acc_last = |(beat_acc & req_last);
  end

  // Output mux: zero-latency pass-through of the granted requester while transferring
  always_comb begin
    req_rdy  = '0;
    fifo_din = '0;
    if (state == ST_XFER) begin
      if (!fifo_full && !fifo_wr_rst_busy) begin
        req_rdy = gnt_oh;
      end
      for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
        if (gnt_id == C_ID_WTH'(i)) begin
          fifo_din = C_DIN_WTH'({req_meta[i*C_META_WTH +: C_META_WTH],
                                 req_pyld[i*C_PYLD_WTH +: C_PYLD_WTH]});
        end
      end
    end
    fifo_wr_en = |(req_vld & req_rdy);
  end

  // Arbitration FSM with grant register, beat counter and sticky length error
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_id   <= C_ID_WTH'(C_NUM_REQ - 1);
      gnt_oh   <= {1'b1, {(C_NUM_REQ-1){1'b0}}};
      beat_cnt <= '0;
      pkt_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_vld && !fifo_wr_rst_busy) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (arb_any && !fifo_wr_rst_busy) begin
            gnt_id   <= arb_idx;
            gnt_oh   <= arb_onehot;
            beat_cnt <= '0;
            state    <= ST_XFER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (acc_any) begin
            if (acc_last) begin
              beat_cnt <= '0;
              state    <= (|req_vld) ? ST_ARB : ST_IDLE;
            end else begin
              if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
              end
              if (beat_cnt == BEAT_CNT_WTH'(C_MAX_BEATS - 1)) begin
                pkt_err <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_XFER);

`ifdef TRANS_EG_ARB_STATS_EN
  logic [STAT_CNT_WTH-1:0] stat_q [C_NUM_REQ];

  // Count accepted last beats per requester; counters wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
        if (beat_acc[i] && req_last[i]) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
    end
  end

  // Pack the counters onto the flat statistics bus
  always_comb begin
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      stat_pkt_cnt[i*STAT_CNT_WTH +: STAT_CNT_WTH] = stat_q[i];
    end
  end
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_arb.sv
// Self-checking bench for the transfer egress packet arbiter.
module tb_cnn_layer_accel_trans_eg_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned MW  = 16;
  localparam int unsigned PW  = 32;
  localparam int unsigned MB  = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned DW  = MW + PW;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_vld;
  logic [N-1:0]     req_last;
  logic [N*MW-1:0]  req_meta;
  logic [N*PW-1:0]  req_pyld;
  logic [N-1:0]     req_rdy;
  logic [DW-1:0]    fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic             fifo_wr_rst_busy;
  logic [IDW-1:0]   gnt_id;
  logic             busy;
  logic             pkt_err;
  logic [N*32-1:0]  stat_pkt_cnt;

  cnn_layer_accel_trans_eg_arb #(
    .C_NUM_REQ   (N),
    .C_META_WTH  (MW),
    .C_PYLD_WTH  (PW),
    .C_MAX_BEATS (MB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_vld          (req_vld),
    .req_last         (req_last),
    .req_meta         (req_meta),
    .req_pyld         (req_pyld),
    .req_rdy          (req_rdy),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_wr_rst_busy (fifo_wr_rst_busy),
    .gnt_id           (gnt_id),
    .busy             (busy),
    .pkt_err          (pkt_err),
    .stat_pkt_cnt     (stat_pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pending packets per requester and transfer progress
  int unsigned len_q  [N][$];
  logic [31:0] base_q [N][$];
  int          beat_idx [N];
  int          done_cnt [N];
  int          owner;
  int          last_win;
  bit          model_err;
  bit          busy_prev;
  logic [N-1:0] vld_prev;
  bit          rb_prev;
  bit          en_bubble, en_full, en_rstbusy;
  int          cyc;
  int          first_wr, last_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int r, input logic [31:0] base, input int idx);
    logic [MW-1:0] m;
    logic [PW-1:0] p;
    m = {4'(r), base[7:0], 4'(idx)};
    p = base ^ {4{8'(idx)}};
    return {m, p};
  endfunction

  // Round-robin rule: first valid requester after the previous winner, wrapping
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic enq(input int r, input int unsigned len);
    len_q[r].push_back(len);
    base_q[r].push_back($urandom);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (len_q[i].size() != 0) return 1'b0;
    return (owner < 0);
  endfunction

  task automatic drive();
    logic [DW-1:0] bd;
    for (int i = 0; i < N; i++) begin
      if (len_q[i].size() != 0) begin
        req_vld[i]  = (beat_idx[i] > 0 && en_bubble) ? ($urandom_range(3, 0) != 0) : 1'b1;
        req_last[i] = (beat_idx[i] == int'(len_q[i][0]) - 1);
        bd = beat_data(i, base_q[i][0], beat_idx[i]);
      end else begin
        req_vld[i]  = 1'b0;
        req_last[i] = 1'(($urandom_range(1, 0)));
        bd = {$urandom, $urandom};
      end
      req_meta[i*MW +: MW] = bd[DW-1:PW];
      req_pyld[i*PW +: PW] = bd[PW-1:0];
    end
    fifo_full        = en_full    ? ($urandom_range(4, 0) == 0)  : 1'b0;
    fifo_wr_rst_busy = en_rstbusy ? ($urandom_range(19, 0) == 0) : 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] mask, exp_rdy;
    bit exp_wr;
    int o, e;
    @(posedge clk);
    #1;
    cyc++;
    chk("pkt_err", 64'(pkt_err), 64'(model_err));
    if (busy && !busy_prev) begin
      e = rr_pick(last_win, vld_prev);
      chk("gnt_rr", 64'(gnt_id), 64'(e));
      chk("gnt_during_rstbusy", 64'(rb_prev), 64'(0));
      if (e >= 0) begin
        owner    = e;
        last_win = e;
      end
    end
    busy_prev = busy;
    drive();
    vld_prev = req_vld;
    rb_prev  = fifo_wr_rst_busy;
    #1;
    mask = '0;
    if (owner >= 0) mask[owner] = 1'b1;
    exp_rdy = (owner >= 0 && !fifo_full && !fifo_wr_rst_busy) ? mask : '0;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    exp_wr = |(req_vld & exp_rdy);
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
    if (exp_wr) begin
      o = owner;
      chk("fifo_din", 64'(fifo_din), 64'(beat_data(o, base_q[o][0], beat_idx[o])));
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (beat_idx[o] == MB - 1 && len_q[o][0] > MB) model_err = 1'b1;
      beat_idx[o]++;
      if (beat_idx[o] == int'(len_q[o][0])) begin
        void'(len_q[o].pop_front());
        void'(base_q[o].pop_front());
        beat_idx[o] = 0;
        done_cnt[o]++;
        owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0; req_last = '0; req_meta = '0; req_pyld = '0;
    fifo_full = 1'b0; fifo_wr_rst_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("rst_din", 64'(fifo_din), 64'(0));
    chk("rst_gnt_id", 64'(gnt_id), 64'(N - 1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pkt_err", 64'(pkt_err), 64'(0));
    for (int i = 0; i < N; i++) chk("rst_stat", 64'(stat_pkt_cnt[i*32 +: 32]), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      len_q[i].delete();
      base_q[i].delete();
      beat_idx[i] = 0;
      done_cnt[i] = 0;
    end
    owner = -1; last_win = N - 1; model_err = 1'b0;
    busy_prev = 1'b0; vld_prev = '0; rb_prev = 1'b0;
    first_wr = -1; last_wr = -1;
  endtask

  task automatic run_until_empty(input int limit);
    int n;
    n = 0;
    while (!all_empty() && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(all_empty()), 64'(1));
  endtask

  task automatic chk_stats();
    for (int i = 0; i < N; i++) begin
`ifdef TRANS_EG_ARB_STATS_EN
      chk("stat_pkt_cnt", 64'(stat_pkt_cnt[i*32 +: 32]), 64'(done_cnt[i]));
`else
      chk("stat_pkt_cnt", 64'(stat_pkt_cnt[i*32 +: 32]), 64'(0));
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    cyc = 0;
    en_bubble = 1'b0; en_full = 1'b0; en_rstbusy = 1'b0;

    // Single-beat packet from requester 0: written two cycles after vld rises
    do_reset();
    enq(0, 1);
    start = cyc;
    run_until_empty(50);
    chk("first_write_latency", 64'(first_wr - start - 1), 64'(2));
    step();
    chk_stats();

    // All four requesters with back-to-back 3-beat packets: strict rotation, one gap cycle
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) enq(i, 3);
    run_until_empty(200);
    chk("rr_span", 64'(last_wr - first_wr), 64'(8 * 3 + 7 - 1));
    step();
    chk_stats();

    // Over-length packet: error rises on the 4th beat, all 6 beats still written, sticky
    do_reset();
    enq(1, 6);
    run_until_empty(100);
    repeat (3) step();
    chk("pkt_err_sticky", 64'(pkt_err), 64'(1));

    // Reset mid-packet aborts back to reset values
    do_reset();
    enq(2, 4);
    n = 0;
    while (beat_idx[2] < 2 && n < 50) begin
      step();
      n++;
    end
    chk("midpkt_reached", 64'(n < 50), 64'(1));
    chk("midpkt_busy", 64'(busy), 64'(1));
    do_reset();

    // Randomized traffic with bubbles, backpressure and write-reset-busy
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      en_bubble = 1'b1; en_full = 1'b1; en_rstbusy = (pass == 1);
      for (int p = 0; p < 8; p++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(3, 0) != 0) enq(i, $urandom_range(6, 1));
        end
      end
      run_until_empty(4000);
      en_bubble = 1'b0; en_full = 1'b0; en_rstbusy = 1'b0;
      step();
      chk_stats();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
